sym_timing_rec: RTL and testbench
=================================

SYM_TIMING_REC -- requirements
Module: sym_timing_rec

Interface
REQ-001 SHALL have parameter OSF, default 20, meaning samples per symbol (range 4..64).
REQ-002 SHALL have parameter WI, default 18, meaning input I/Q width, matching the matched-filter output.
REQ-003 SHALL have parameter WO, default 16, meaning symbol output width (WO < WI).
REQ-004 SHALL have parameter WIN, default 16, meaning symbols per error-accumulation window (power of 2).
REQ-005 SHALL have parameter THRESH, default 1024, meaning accumulated-error magnitude that triggers a phase step.
REQ-006 SHALL have parameter LOCK_N, default 4, meaning consecutive windows without a step needed to declare lock.
REQ-007 SHALL have parameter P_INIT, default OSF/2, meaning reset sampling phase.
REQ-008 SHALL have port clk, input, 1 bit: single clock for all logic.
REQ-009 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-010 SHALL have port i_in, input, WI bits signed: filtered I sample.
REQ-011 SHALL have port q_in, input, WI bits signed: filtered Q sample.
REQ-012 SHALL have port iq_val_i, input, 1 bit: sample qualifier (gaps allowed).
REQ-013 SHALL have port i_sym, output, WO bits signed: on-time I symbol.
REQ-014 SHALL have port q_sym, output, WO bits signed: on-time Q symbol.
REQ-015 SHALL have port sym_val_o, output, 1 bit: one-cycle symbol strobe.
REQ-016 SHALL have port phase_o, output, $clog2(OSF) bits: current sampling phase p.
REQ-017 SHALL have port lock_o, output, 1 bit: timing loop locked.

Function
REQ-018 SHALL advance all state only on cycles with iq_val_i=1; iq_val_i=0 cycles are ignored.
REQ-019 SHALL keep sample counter cnt, 0..OSF-1, incrementing per valid sample and wrapping OSF-1 -> 0.
REQ-020 SHALL keep a 2-deep valid-sample delay line: d1 = previous sample, d2 = the sample before d1.
REQ-021 SHALL decide on the valid cycle where cnt == (p+1) mod OSF: late = current input, on-time = d1, early = d2.
REQ-022 SHALL, one cycle after a decision, pulse sym_val_o for exactly one cycle, with i_sym/q_sym = on-time sample rounded (add 2^(WI-WO-1), drop WI-WO LSBs) and saturated to WO bits.
REQ-023 SHALL hold i_sym/q_sym between strobes.
REQ-024 SHALL compute mag = |I|+|Q| (WI+1 bits unsigned) and e = mag(late) - mag(early) (WI+2 bits signed), with |-2^(WI-1)| = 2^(WI-1) and no wrap.
REQ-025 SHALL add e to a signed accumulator of width WI+2+$clog2(WIN) at each decision, with no overflow possible.
REQ-026 SHALL, after WIN decisions: set pending = +1 if acc > THRESH, -1 if acc < -THRESH, else 0; then clear acc and the window count.
REQ-027 SHALL apply a pending step on the first valid cycle with cnt == OSF-1 strictly after the window end: p <= (p + step) mod OSF; pending then clears.
REQ-028 SHALL produce exactly one decision per OSF-sample period across phase wrap (OSF-1 -> 0 and 0 -> OSF-1); no symbol is dropped or duplicated.
REQ-029 SHALL implement FSM SEARCH/LOCKED: a window with step 0 increments quiet_cnt; a nonzero step clears quiet_cnt.
REQ-030 SHALL transition SEARCH -> LOCKED when quiet_cnt reaches LOCK_N, and LOCKED -> SEARCH on any nonzero step.
REQ-031 SHALL drive lock_o = 1 iff the state is LOCKED (registered).
REQ-032 SHALL drive phase_o directly from the p register.

Reset
REQ-033 SHALL, with rst low, immediately force: cnt=0, p=P_INIT, d1=d2=0, acc=0, window count 0, pending 0, quiet_cnt 0, state SEARCH, i_sym=q_sym=0, sym_val_o=0, lock_o=0.
REQ-034 SHALL discard any in-flight decision or pending step when reset is asserted mid-window; after release, operation restarts at cnt=0.

Verification
REQ-035 SHALL pass: OSF=20, p=10, constant input I=1000, Q=0 -> sym_val_o every 20 valid samples, first strobe 1 cycle after the 12th valid sample; i_sym=250; e=0 and lock_o=1 after 4 windows (64 symbols).
REQ-036 SHALL pass: periodic symbol pulse peaking 3 samples after phase 10 -> phase_o steps 10->11->12->13, then holds, and lock_o rises after 4 quiet windows.
REQ-037 SHALL pass: p=19 with a +1 step pending -> p becomes 0, and exactly one strobe occurs in each of the two periods around the wrap.
REQ-038 SHALL pass: i_in = 131071 and then -131072 on-time -> i_sym = 32767 and then -32768 (saturation and rounding).
REQ-039 SHALL pass: iq_val_i toggling 50% duty -> strobes and results identical to a gap-free run after filtering on valid.
REQ-040 SHALL pass: rst pulsed low mid-window while locked -> lock_o=0 and phase_o=10 asynchronously, and no strobe until 12 further valid samples.

Source files
------------

// File: rtl/sym_timing_rec.sv
// Early/late-gate symbol timing recovery: picks one on-time sample per OSF-sample period,
// accumulates |late|-|early| over a window and nudges the sampling phase by +/-1.
module sym_timing_rec #(
  parameter int OSF    = 20,
  parameter int WI     = 18,
  parameter int WO     = 16,
  parameter int WIN    = 16,
  parameter int THRESH = 1024,
  parameter int LOCK_N = 4,
  parameter int P_INIT = OSF / 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic signed [WI-1:0]   i_in,
  input  logic signed [WI-1:0]   q_in,
  input  logic                   iq_val_i,
  output logic signed [WO-1:0]   i_sym,
  output logic signed [WO-1:0]   q_sym,
  output logic                   sym_val_o,
  output logic [$clog2(OSF)-1:0] phase_o,
  output logic                   lock_o
);

  localparam int PW  = $clog2(OSF);
  localparam int EW  = WI + 2;
  localparam int AW  = EW + $clog2(WIN);
  localparam int WCW = (WIN > 1) ? $clog2(WIN) : 1;
  localparam int QW  = $clog2(LOCK_N + 1);
  localparam int SH  = WI - WO;

  localparam logic [WI:0]            RND     = (WI+1)'(1) << (SH - 1);
  localparam logic signed [WO-1:0]   SYM_MAX = {1'b0, {(WO-1){1'b1}}};
  localparam logic signed [WO-1:0]   SYM_MIN = {1'b1, {(WO-1){1'b0}}};
  localparam logic signed [AW-1:0]   THR_P   = AW'(THRESH);
  localparam logic signed [AW-1:0]   THR_N   = -THR_P;

  typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;
  state_t state_reg, state_next;

  logic [PW-1:0]        cnt_reg, p_reg, p_next, dec_pt;
  logic signed [WI-1:0] smp [2];
  logic signed [WI-1:0] d1_reg [2];
  logic signed [WI-1:0] d2_reg [2];
  logic signed [WO-1:0] sym_reg [2];
  logic signed [WO-1:0] rnd [2];
  logic                 sym_val_reg;
  logic signed [AW-1:0] acc_reg, acc_sum;
  logic [WCW-1:0]       win_reg;
  logic                 pend_up_reg, pend_dn_reg, skip_reg;
  logic [QW-1:0]        quiet_reg, quiet_inc;
  logic [WI:0]          mag_late, mag_early;
  logic signed [EW-1:0] err;
  logic                 last, hit, dec, win_end, apply, step_up, step_dn;

  // |I|+|Q| without wrap: the most negative input maps to 2^(WI-1)
  function automatic logic [WI:0] mag_f(input logic signed [WI-1:0] a,
                                        input logic signed [WI-1:0] b);
    logic [WI-1:0] aa, ab;
    aa = a[WI-1] ? $unsigned(-a) : $unsigned(a);
    ab = b[WI-1] ? $unsigned(-b) : $unsigned(b);
    return {1'b0, aa} + {1'b0, ab};
  endfunction

  assign smp[0] = i_in;
  assign smp[1] = q_in;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_round
      logic signed [WI:0] biased;
      logic signed [WO:0] trunc;
      assign biased  = {d1_reg[gi][WI-1], d1_reg[gi]} + RND;
      assign trunc   = (WO+1)'(biased >>> SH);
      assign rnd[gi] = (trunc[WO] != trunc[WO-1]) ? (trunc[WO] ? SYM_MIN : SYM_MAX)
                                                  : trunc[WO-1:0];
    end
  endgenerate

  assign mag_late  = mag_f(i_in, q_in);
  assign mag_early = mag_f(d2_reg[0], d2_reg[1]);
  assign err       = $signed({1'b0, mag_late}) - $signed({1'b0, mag_early});
  assign acc_sum   = acc_reg + AW'(err);
  assign step_up   = acc_sum > THR_P;
  assign step_dn   = acc_sum < THR_N;

  assign dec_pt  = (p_reg == PW'(OSF - 1)) ? '0 : p_reg + PW'(1);
  assign last    = (cnt_reg == PW'(OSF - 1));
  assign hit     = iq_val_i && (cnt_reg == dec_pt);
  // A +1 step out of p=OSF-2 moves the decision from the last sample to the very next one;
  // skip_reg suppresses that back-to-back decision so each period yields one symbol.
  assign dec     = hit && !skip_reg;
  assign win_end = dec && (win_reg == WCW'(WIN - 1));
  assign apply   = iq_val_i && last && (pend_up_reg || pend_dn_reg);
  assign quiet_inc = (quiet_reg == QW'(LOCK_N)) ? quiet_reg : quiet_reg + QW'(1);

  always_comb begin
    p_next = p_reg;
    if (apply) begin
      if (pend_up_reg)
        p_next = (p_reg == PW'(OSF - 1)) ? '0 : p_reg + PW'(1);
      else
        p_next = (p_reg == '0) ? PW'(OSF - 1) : p_reg - PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg     <= '0;
      p_reg       <= PW'(P_INIT);
      acc_reg     <= '0;
      win_reg     <= '0;
      pend_up_reg <= 1'b0;
      pend_dn_reg <= 1'b0;
      skip_reg    <= 1'b0;
      quiet_reg   <= '0;
      sym_val_reg <= 1'b0;
      for (int k = 0; k < 2; k++) begin
        d1_reg[k]  <= '0;
        d2_reg[k]  <= '0;
        sym_reg[k] <= '0;
      end
    end else begin
      sym_val_reg <= dec;
      if (iq_val_i) begin
        cnt_reg <= last ? '0 : cnt_reg + PW'(1);
        p_reg   <= p_next;
        for (int k = 0; k < 2; k++) begin
          d1_reg[k] <= smp[k];
          d2_reg[k] <= d1_reg[k];
        end
      end
      if (dec) begin
        for (int k = 0; k < 2; k++) sym_reg[k] <= rnd[k];
        acc_reg <= win_end ? '0 : acc_sum;
        win_reg <= win_end ? '0 : win_reg + WCW'(1);
      end
      // a window closing on the same cycle a step is applied re-arms the next step
      if (win_end) begin
        pend_up_reg <= step_up;
        pend_dn_reg <= step_dn;
        quiet_reg   <= (step_up || step_dn) ? '0 : quiet_inc;
      end else if (apply) begin
        pend_up_reg <= 1'b0;
        pend_dn_reg <= 1'b0;
      end
      if (apply && pend_up_reg && dec)
        skip_reg <= 1'b1;
      else if (hit && skip_reg)
        skip_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= SEARCH;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (win_end) begin
      if (step_up || step_dn)
        state_next = SEARCH;
      else if (quiet_inc == QW'(LOCK_N))
        state_next = LOCKED;
    end
  end

  assign i_sym     = sym_reg[0];
  assign q_sym     = sym_reg[1];
  assign sym_val_o = sym_val_reg;
  assign phase_o   = p_reg;
  assign lock_o    = (state_reg == LOCKED);

endmodule

// File: tb/tb_sym_timing_rec.sv
// Directed bench for sym_timing_rec: constant input, phase pull-in, wrap, saturation,
// gapped valid and mid-window reset.
module tb_sym_timing_rec;

  localparam int WI = 18;
  localparam int WO = 16;
  localparam int PW = 5;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic signed [WI-1:0] i_in = '0, q_in = '0, i_in2 = '0, q_in2 = '0;
  logic                 iq_val = 1'b0, iq_val2 = 1'b0;
  logic signed [WO-1:0] i_sym, q_sym, i_sym2, q_sym2;
  logic                 sym_val, sym_val2, lock, lock2;
  logic [PW-1:0]        phase, phase2;

  int checks = 0;
  int failures = 0;

  int st_n [200];
  int st_p [200];
  int st_l [200];
  int st_i [200];
  int nst;

  always #5 clk = ~clk;

  sym_timing_rec dut (
    .clk(clk), .rst(rst), .i_in(i_in), .q_in(q_in), .iq_val_i(iq_val),
    .i_sym(i_sym), .q_sym(q_sym), .sym_val_o(sym_val), .phase_o(phase), .lock_o(lock)
  );

  sym_timing_rec #(.P_INIT(19)) dut2 (
    .clk(clk), .rst(rst), .i_in(i_in2), .q_in(q_in2), .iq_val_i(iq_val2),
    .i_sym(i_sym2), .q_sym(q_sym2), .sym_val_o(sym_val2), .phase_o(phase2), .lock_o(lock2)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end else begin
      $display("  ok %s = %0d", tag, got);
    end
  endtask

  task automatic send(input logic v, input int i, input int q);
    iq_val = v;
    i_in   = i[WI-1:0];
    q_in   = q[WI-1:0];
    @(posedge clk);
    #1;
  endtask

  task automatic send2(input logic v, input int i, input int q);
    iq_val2 = v;
    i_in2   = i[WI-1:0];
    q_in2   = q[WI-1:0];
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    iq_val  = 1'b0;
    iq_val2 = 1'b0;
    rst     = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  function automatic int pulse(input int c);
    int d;
    d = c - 13;
    if (d < 0) d = -d;
    return 1000 - 50 * d;
  endfunction

  // Triangle peaking at cnt=13: phase must climb 10->11->12->13, then lock after 4 quiet windows.
  task automatic run_pulse(input bit gaps, input string tag);
    int gap_err;
    gap_err = 0;
    nst = 0;
    for (int n = 0; n < 2240; n++) begin
      if (gaps) begin
        send(1'b0, 99999, -99999);
        if (sym_val) gap_err++;
      end
      send(1'b1, pulse(n % 20), 0);
      if (sym_val && nst < 200) begin
        st_n[nst] = n;
        st_p[nst] = int'(phase);
        st_l[nst] = int'(lock);
        st_i[nst] = int'(i_sym);
        nst++;
      end
    end
    check({tag, "_nstrobes"}, nst, 112);
    check({tag, "_first_n"}, st_n[0], 11);
    check({tag, "_w1_last_n"}, st_n[15], 311);
    check({tag, "_w1_last_phase"}, st_p[15], 10);
    check({tag, "_w2_first_n"}, st_n[16], 332);
    check({tag, "_w2_phase"}, st_p[16], 11);
    check({tag, "_w3_first_n"}, st_n[32], 653);
    check({tag, "_w3_phase"}, st_p[32], 12);
    check({tag, "_w4_first_n"}, st_n[48], 974);
    check({tag, "_w4_phase"}, st_p[48], 13);
    check({tag, "_lock_before"}, st_l[110], 0);
    check({tag, "_lock_after"}, st_l[111], 1);
    check({tag, "_last_n"}, st_n[111], 2234);
    check({tag, "_last_phase"}, st_p[111], 13);
    check({tag, "_last_isym"}, st_i[111], 250);
    if (gaps) check({tag, "_gap_strobes"}, gap_err, 0);
  endtask

  initial begin
    int first, prev, sp_err, lk62, lk63, early, c1, c2, n_wrap, i300, i321, ph318, ph319, first2;

    // reset state
    @(posedge clk);
    #1;
    check("rst_symval", sym_val, 0);
    check("rst_lock", lock, 0);
    check("rst_phase", phase, 10);
    check("rst_isym", i_sym, 0);
    check("rst_phase2", phase2, 19);
    do_reset();

    // rounding and saturation of the on-time sample
    for (int n = 0; n < 52; n++) begin
      int iv, qv;
      iv = (n == 10) ? 131071 : (n == 30) ? -131072 : (n == 50) ? -5 : 0;
      qv = (n == 50) ? 6 : 0;
      send(1'b1, iv, qv);
      if (n == 10) check("sat_no_strobe_yet", sym_val, 0);
      if (n == 11) begin
        check("sat_pos_strobe", sym_val, 1);
        check("sat_pos_isym", i_sym, 32767);
        check("sat_pos_qsym", q_sym, 0);
      end
      if (n == 12) check("strobe_one_cycle", sym_val, 0);
      if (n == 20) check("hold_isym", i_sym, 32767);
      if (n == 31) check("sat_neg_isym", i_sym, -32768);
      if (n == 51) begin
        check("rnd_neg_isym", i_sym, -1);
        check("rnd_pos_qsym", q_sym, 2);
      end
    end

    // constant I=1000: strobe every 20 samples, zero error, lock after 4 windows
    do_reset();
    nst = 0; first = -1; prev = 0; sp_err = 0; lk62 = -1; lk63 = -1;
    for (int n = 0; n < 1272; n++) begin
      send(1'b1, 1000, 0);
      if (sym_val) begin
        if (nst == 0) first = n;
        else if (n - prev != 20) sp_err++;
        prev = n;
        if (nst == 62) lk62 = int'(lock);
        if (nst == 63) lk63 = int'(lock);
        nst++;
      end
    end
    check("const_first_n", first, 11);
    check("const_nstrobes", nst, 64);
    check("const_spacing_err", sp_err, 0);
    check("const_lock_63", lk62, 0);
    check("const_lock_64", lk63, 1);
    check("const_phase", phase, 10);
    check("const_isym", i_sym, 250);
    check("const_qsym", q_sym, 0);

    // phase pull-in, gap-free then with 50% valid duty
    do_reset();
    run_pulse(1'b0, "pulse");
    do_reset();
    run_pulse(1'b1, "gapped");

    // asynchronous reset mid-window while locked
    #2;
    rst = 1'b0;
    #1;
    check("arst_lock", lock, 0);
    check("arst_phase", phase, 10);
    check("arst_symval", sym_val, 0);
    check("arst_isym", i_sym, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    early = 0;
    for (int n = 0; n < 12; n++) begin
      send(1'b1, 1000, 0);
      if (n < 11 && sym_val) early++;
      if (n == 11) begin
        check("arst_restart_strobe", sym_val, 1);
        check("arst_restart_isym", i_sym, 250);
      end
    end
    check("arst_no_early_strobe", early, 0);

    // phase wrap 19 -> 0 on the second instance
    do_reset();
    c1 = 0; c2 = 0; n_wrap = -1; i300 = -1; i321 = -1; ph318 = -1; ph319 = -1; first2 = -1;
    for (int n = 0; n < 360; n++) begin
      send2(1'b1, (n % 20 == 0) ? 1000 : 500, 0);
      if (sym_val2) begin
        if (first2 < 0) first2 = n;
        if (n >= 300 && n < 320) c1++;
        if (n >= 320 && n < 340) begin
          c2++;
          n_wrap = n;
        end
        if (n == 300) i300 = int'(i_sym2);
        if (n == 321) i321 = int'(i_sym2);
      end
      if (n == 318) ph318 = int'(phase2);
      if (n == 319) ph319 = int'(phase2);
    end
    check("wrap_first_n", first2, 0);
    check("wrap_phase_before", ph318, 19);
    check("wrap_phase_after", ph319, 0);
    check("wrap_strobes_pre", c1, 1);
    check("wrap_strobes_post", c2, 1);
    check("wrap_post_n", n_wrap, 321);
    check("wrap_isym_pre", i300, 125);
    check("wrap_isym_post", i321, 250);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
